cva6_rvfi_trace_fifo: RTL

- Sequential successor to the combinational RVFI probe packer.
- Captures up to NR_IN retired-instruction records per cycle from the commit stage and compacts them in program order into a circular buffer of DEPTH entries.
- Drains them over NR_OUT in-order valid/ready lanes toward the RVFI/trace consumer, tagging each record with a 64-bit retirement order number.
- Handles overflow without stalling commit (drop, count, flag). Optionally filters records retired in debug mode.

---
 rtl/cva6_rvfi_trace_fifo.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/cva6_rvfi_trace_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cva6_rvfi_trace_fifo
//  Description : Captures up to NR_IN retired-instruction records per cycle,
//                compacts them in program order into a circular buffer, tags
//                each with a 64-bit retirement order number and drains them
//                over NR_OUT in-order valid/ready lanes. Overflow never
//                back-pressures commit: excess records are dropped, counted
//                and flagged.
//  Revision    : 1.0 - initial release
// ============================================================================
module cva6_rvfi_trace_fifo #(
    parameter int unsigned NR_IN      = 2,
    parameter int unsigned NR_OUT     = 1,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned XLEN       = 64,
    parameter bit          DROP_DEBUG = 1'b0
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NR_IN-1:0]           commit_valid_i,
    input  logic [NR_IN*XLEN-1:0]      commit_pc_i,
    input  logic [NR_IN*32-1:0]        commit_insn_i,
    input  logic [NR_IN*5-1:0]         commit_rd_i,
    input  logic [NR_IN*XLEN-1:0]      commit_wdata_i,
    input  logic [NR_IN-1:0]           commit_trap_i,
    input  logic [NR_IN*XLEN-1:0]      commit_cause_i,
    input  logic [1:0]                 priv_lvl_i,
    input  logic                       debug_mode_i,
    output logic [NR_OUT-1:0]          out_valid_o,
    input  logic [NR_OUT-1:0]          out_ready_i,
    output logic [NR_OUT*64-1:0]       out_order_o,
    output logic [NR_OUT*XLEN-1:0]     out_pc_o,
    output logic [NR_OUT*32-1:0]       out_insn_o,
    output logic [NR_OUT*5-1:0]        out_rd_o,
    output logic [NR_OUT*XLEN-1:0]     out_wdata_o,
    output logic [NR_OUT-1:0]          out_trap_o,
    output logic [NR_OUT*XLEN-1:0]     out_cause_o,
    output logic [NR_OUT*2-1:0]        out_priv_o,
    output logic                       overflow_o,
    output logic [15:0]                drop_cnt_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    // Occupancy needs one extra bit to represent a full buffer.
    localparam int unsigned c_CNT_W = $clog2(DEPTH) + 1;
    // A single-entry buffer still needs a one-bit pointer; the mask keeps it at 0.
    localparam int unsigned c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Arithmetic width wide enough for DEPTH + NR_IN without overflow.
    localparam int unsigned c_AW    = c_CNT_W + 3;
    localparam logic [c_PTR_W-1:0] c_PTR_MASK = c_PTR_W'(DEPTH - 1);
    localparam logic [c_AW-1:0]    c_DEPTH    = c_AW'(DEPTH);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [63:0]        r_order;
    logic               r_overflow;
    logic [15:0]        r_drop_cnt;

    logic [63:0]        r_mem_order [DEPTH];
    logic [XLEN-1:0]    r_mem_pc    [DEPTH];
    logic [31:0]        r_mem_insn  [DEPTH];
    logic [4:0]         r_mem_rd    [DEPTH];
    logic [XLEN-1:0]    r_mem_wdata [DEPTH];
    logic               r_mem_trap  [DEPTH];
    logic [XLEN-1:0]    r_mem_cause [DEPTH];
    logic [1:0]         r_mem_priv  [DEPTH];

    // ------------------------------------------------------------------------
    // Combinational
    // ------------------------------------------------------------------------
    logic [NR_IN-1:0]   w_elig;
    logic [c_AW-1:0]    w_rank [NR_IN];
    logic [c_AW-1:0]    w_elig_cnt;
    logic [c_AW-1:0]    w_free;
    logic [c_AW-1:0]    w_acc_cnt;
    logic [c_AW-1:0]    w_drop;
    logic [NR_IN-1:0]   w_accept;
    logic [c_PTR_W-1:0] w_slot [NR_IN];
    logic [c_PTR_W-1:0] w_rd_slot [NR_OUT];
    logic [c_CNT_W-1:0] w_pops;
    logic               w_run;
    logic [16:0]        w_drop_sum;

    // Eligibility per lane; debug-mode records vanish entirely when filtered.
    always_comb begin
        w_elig = commit_valid_i & {NR_IN{!(DROP_DEBUG && debug_mode_i)}};
    end

    // Prefix count of eligible lanes gives each lane its compacted position.
    always_comb begin
        w_elig_cnt = '0;
        for (int k = 0; k < NR_IN; k++) begin
            w_rank[k]  = w_elig_cnt;
            w_elig_cnt = w_elig_cnt + c_AW'(w_elig[k]);
        end
    end

    // Capacity uses the start-of-cycle occupancy, so same-cycle pops never make room.
    always_comb begin
        w_free     = c_DEPTH - c_AW'(r_count);
        w_acc_cnt  = (w_elig_cnt < w_free) ? w_elig_cnt : w_free;
        w_drop     = w_elig_cnt - w_acc_cnt;
        w_drop_sum = {1'b0, r_drop_cnt} + 17'(w_drop);
        for (int k = 0; k < NR_IN; k++) begin
            w_accept[k] = w_elig[k] && (w_rank[k] < w_free);
            w_slot[k]   = (r_wr_ptr + w_rank[k][c_PTR_W-1:0]) & c_PTR_MASK;
        end
    end

    // Drain lanes present consecutive slots from the read pointer.
    always_comb begin
        for (int j = 0; j < NR_OUT; j++) begin
            w_rd_slot[j]   = (r_rd_ptr + c_PTR_W'(j)) & c_PTR_MASK;
            out_valid_o[j] = (r_count > c_CNT_W'(j));
        end
    end

    // Only an unbroken run of accepted lanes from lane 0 is popped.
    always_comb begin
        w_pops = '0;
        w_run  = 1'b1;
        for (int j = 0; j < NR_OUT; j++) begin
            if (w_run && out_valid_o[j] && out_ready_i[j]) begin
                w_pops = w_pops + 1'b1;
            end else begin
                w_run = 1'b0;
            end
        end
    end

    // Record fields are read straight from storage; don't-care while invalid.
    always_comb begin
        out_order_o = '0;
        out_pc_o    = '0;
        out_insn_o  = '0;
        out_rd_o    = '0;
        out_wdata_o = '0;
        out_trap_o  = '0;
        out_cause_o = '0;
        out_priv_o  = '0;
        for (int j = 0; j < NR_OUT; j++) begin
            out_order_o[j*64   +: 64]   = r_mem_order[w_rd_slot[j]];
            out_pc_o   [j*XLEN +: XLEN] = r_mem_pc   [w_rd_slot[j]];
            out_insn_o [j*32   +: 32]   = r_mem_insn [w_rd_slot[j]];
            out_rd_o   [j*5    +: 5]    = r_mem_rd   [w_rd_slot[j]];
            out_wdata_o[j*XLEN +: XLEN] = r_mem_wdata[w_rd_slot[j]];
            out_trap_o [j]              = r_mem_trap [w_rd_slot[j]];
            out_cause_o[j*XLEN +: XLEN] = r_mem_cause[w_rd_slot[j]];
            out_priv_o [j*2    +: 2]    = r_mem_priv [w_rd_slot[j]];
        end
    end

    // Pointers, occupancy, order counter and drop bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_order    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_wr_ptr <= (r_wr_ptr + w_acc_cnt[c_PTR_W-1:0]) & c_PTR_MASK;
            r_rd_ptr <= (r_rd_ptr + w_pops[c_PTR_W-1:0]) & c_PTR_MASK;
            r_count  <= r_count + w_acc_cnt[c_CNT_W-1:0] - w_pops;
            // Dropped records still consume order numbers so gaps are visible.
            r_order  <= r_order + 64'(w_elig_cnt);
            if (w_drop != '0) begin
                r_overflow <= 1'b1;
            end
            r_drop_cnt <= w_drop_sum[16] ? 16'hFFFF : w_drop_sum[15:0];
        end
    end

    // Record storage; accepted lanes land in distinct free slots.
    always_ff @(posedge clk_i) begin
        for (int k = 0; k < NR_IN; k++) begin
            if (w_accept[k]) begin
                r_mem_order[w_slot[k]] <= r_order + 64'(w_rank[k]);
                r_mem_pc   [w_slot[k]] <= commit_pc_i   [k*XLEN +: XLEN];
                r_mem_insn [w_slot[k]] <= commit_insn_i [k*32   +: 32];
                r_mem_rd   [w_slot[k]] <= commit_rd_i   [k*5    +: 5];
                r_mem_wdata[w_slot[k]] <= commit_wdata_i[k*XLEN +: XLEN];
                r_mem_trap [w_slot[k]] <= commit_trap_i [k];
                r_mem_cause[w_slot[k]] <= commit_cause_i[k*XLEN +: XLEN];
                r_mem_priv [w_slot[k]] <= priv_lvl_i;
            end
        end
    end

    assign overflow_o = r_overflow;
    assign drop_cnt_o = r_drop_cnt;
    assign count_o    = r_count;

endmodule
`default_nettype wire
